data_unpack_sched: RTL and testbench

DATA_UNPACK_SCHED -- requirements
Module: data_unpack_sched

---
 rtl/unpack_pkg.sv | 12 +
 rtl/lane_serializer.sv | 37 +++
 rtl/data_unpack_sched.sv | 70 +++++++
 tb/tb_data_unpack_sched.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/unpack_pkg.sv
// unpack_pkg: shared state encoding and lane-geometry helpers for the unpack scheduler
package unpack_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
  function automatic int clog2f(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin end
    return r;
  endfunction
  function automatic int lanes_of(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction
endpackage

// File: rtl/lane_serializer.sv
// lane_serializer: shift register plus lane counter; load captures a word, advance steps one lane
//   in : clk, rst, load, load_data[IN_WIDTH], advance
//   out: lane[OUT_WIDTH] (current lane, lowest bits first), last (current lane is LANES-1)
module lane_serializer
  import unpack_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [IN_WIDTH-1:0]  load_data,
  input  logic                 advance,
  output logic [OUT_WIDTH-1:0] lane,
  output logic                 last
);
  localparam int LANES = lanes_of(IN_WIDTH, OUT_WIDTH);
  localparam int CW = clog2f(LANES);
  logic [IN_WIDTH-1:0] sr;
  logic [CW-1:0] cnt;
  // counter wraps naturally to 0 after lane LANES-1
  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= load_data;
      cnt <= '0;
    end else if (advance) begin
      sr  <= sr >> OUT_WIDTH;
      cnt <= cnt + 1'b1;
    end
  end
  assign lane = sr[OUT_WIDTH-1:0];
  assign last = cnt == CW'(LANES - 1);
endmodule

// File: rtl/data_unpack_sched.sv
// data_unpack_sched: arbitrates two word requesters and streams each granted word as LANES lanes
//   in : clk, rst, s0/s1_valid, s0/s1_data[IN_WIDTH], out_ready
//   out: s0/s1_ready, out_valid, out_data[OUT_WIDTH], out_src, out_last, busy
//   UNPACK_SCHED_FIXED_PRIO_EN: requester 0 always wins; otherwise round-robin per word
module data_unpack_sched
  import unpack_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s0_valid,
  input  logic [IN_WIDTH-1:0]  s0_data,
  input  logic                 s1_valid,
  input  logic [IN_WIDTH-1:0]  s1_data,
  output logic                 s0_ready,
  output logic                 s1_ready,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_src,
  output logic                 out_last,
  output logic                 busy
);
  state_t state, state_nx;
  logic consume, done, can_acc, g1, accept, src_q;
  assign consume = out_valid & out_ready;
  assign done    = consume & out_last;
  // accepting during the last-lane cycle gives zero-bubble back-to-back words
  assign can_acc = !rst && (state == IDLE || done);
`ifdef UNPACK_SCHED_FIXED_PRIO_EN
  assign g1 = s1_valid & !s0_valid;
`else
  logic last_grant;
  assign g1 = s1_valid & (!s0_valid | !last_grant);
  always_ff @(posedge clk) begin
    if (rst) last_grant <= 1'b1;
    else if (accept) last_grant <= g1;
  end
`endif
  assign s0_ready = can_acc & s0_valid & !g1;
  assign s1_ready = can_acc & g1;
  assign accept   = s0_ready | s1_ready;
  always_comb begin
    state_nx = state;
    state_nx = accept ? SHIFT : (done ? IDLE : state);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      src_q <= 1'b0;
    end else begin
      state <= state_nx;
      src_q <= accept ? g1 : src_q;
    end
  end
  assign out_valid = state == SHIFT;
  assign busy      = state == SHIFT;
  assign out_src   = src_q;
  lane_serializer #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_data (g1 ? s1_data : s0_data),
    .advance   (consume),
    .lane      (out_data),
    .last      (out_last)
  );
endmodule

// File: tb/tb_data_unpack_sched.sv
// tb_data_unpack_sched: scoreboard bench with a lane-queue reference model plus an 8-bit lane instance
module tb_data_unpack_sched;
  localparam int IW = 32, OW = 16, LN = IW / OW;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic s0_valid, s1_valid, out_ready;
  logic [IW-1:0] s0_data, s1_data;
  logic s0_ready, s1_ready, out_valid, out_src, out_last, busy;
  logic [OW-1:0] out_data;
  data_unpack_sched #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst(rst), .s0_valid(s0_valid), .s0_data(s0_data), .s1_valid(s1_valid),
    .s1_data(s1_data), .s0_ready(s0_ready), .s1_ready(s1_ready), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_last(out_last), .busy(busy)
  );
  logic b_rst = 1, b_valid = 0, b_ready = 0, b_s1v = 0;
  logic [31:0] b_data = 0, b_zero = 0;
  logic b_s0r, b_s1r, b_ov, b_src, b_last, b_busy;
  logic [7:0] b_out;
  data_unpack_sched #(.IN_WIDTH(32), .OUT_WIDTH(8)) dut8 (
    .clk(clk), .rst(b_rst), .s0_valid(b_valid), .s0_data(b_data), .s1_valid(b_s1v),
    .s1_data(b_zero), .s0_ready(b_s0r), .s1_ready(b_s1r), .out_ready(b_ready),
    .out_valid(b_ov), .out_data(b_out), .out_src(b_src), .out_last(b_last), .busy(b_busy)
  );
  typedef struct packed {logic src; logic [OW-1:0] d; logic last;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0, n0 = 0, n1 = 0;
  logic mlast = 1, acc0 = 0, acc1 = 0, p;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  function automatic logic pick(input logic v0, input logic v1, input logic lst);
`ifdef UNPACK_SCHED_FIXED_PRIO_EN
    return v1 && !v0;
`else
    return (v0 && v1) ? !lst : v1;
`endif
  endfunction
  // reference: a word is taken exactly when some requester is valid and no lanes remain
  initial forever begin
    @(negedge clk);
    #2;
    if (rst) begin
      chk("ready_in_rst", {30'd0, s0_ready, s1_ready}, 0);
      q.delete();
      mlast = 1;
    end else begin
      chk("ready_any", s0_ready | s1_ready, (s0_valid | s1_valid) && q.size() == 0);
      chk("ready_excl", s0_ready & s1_ready, 0);
      if ((s0_valid | s1_valid) && q.size() == 0) begin
        p = pick(s0_valid, s1_valid, mlast);
        chk("grant_s1", s1_ready, p);
        for (int l = 0; l < LN; l++) begin
          e.src = p;
          e.d = OW'((p ? s1_data : s0_data) >> (OW * l));
          e.last = l == LN - 1;
          q.push_back(e);
        end
        mlast = p;
        if (p) begin acc1 = 1; n1++; end
        else begin acc0 = 1; n0++; end
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("out_valid", out_valid, q.size() != 0);
      chk("busy", busy, q.size() != 0);
      if (out_valid && q.size() != 0) begin
        chk("out_data", out_data, q[0].d);
        chk("out_src", out_src, q[0].src);
        chk("out_last", out_last, q[0].last);
        if (out_ready) void'(q.pop_front());
      end
    end
  end
  task automatic wait_acc(input logic want1);
    int i;
    for (i = 0; i < 20; i++) begin
      cyc();
      if (want1 ? acc1 : acc0) break;
    end
    if (i == 20) chk("accept_timeout", 0, 1);
  endtask
  initial begin
    logic [7:0] exp8 [4];
    int k;
    s0_valid = 0; s1_valid = 0; out_ready = 0; s0_data = 0; s1_data = 0;
    repeat (3) cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    s0_data = 32'hAAAA5555; s0_valid = 1; out_ready = 1; acc0 = 0;
    wait_acc(0);
    s0_valid = 0;
    repeat (4) cyc();
    s0_data = 32'hAAAA5555; s0_valid = 1; acc0 = 0;
    wait_acc(0);
    s0_valid = 0; out_ready = 0;
    repeat (3) cyc();
    out_ready = 1;
    repeat (4) cyc();
    rst = 1; cyc(); cyc(); rst = 0;
    s0_data = 32'h11112222; s1_data = 32'h33334444;
    s0_valid = 1; s1_valid = 1; acc0 = 0; acc1 = 0;
    for (int i = 0; i < 20 && (s0_valid || s1_valid); i++) begin
      cyc();
      if (acc0) s0_valid = 0;
      if (acc1) s1_valid = 0;
    end
    chk("both_accepted", {30'd0, s0_valid, s1_valid}, 0);
    repeat (6) cyc();
    n0 = 0; n1 = 0; s0_valid = 1; s1_valid = 1;
    for (int i = 0; i < 40 && n0 + n1 < 6; i++) begin
      cyc();
      s0_data = $urandom; s1_data = $urandom;
    end
    s0_valid = 0; s1_valid = 0;
`ifdef UNPACK_SCHED_FIXED_PRIO_EN
    chk("fixed_s0_grants", n0, 6);
`else
    chk("rr_s0_grants", n0, 3);
`endif
    repeat (6) cyc();
    s1_valid = 1; s1_data = 32'hBEEF0001; acc1 = 0;
    wait_acc(1);
    s1_valid = 0;
    repeat (4) cyc();
    s0_data = 32'h12345678; s0_valid = 1; out_ready = 0; acc0 = 0;
    wait_acc(0);
    s0_valid = 0;
    rst = 1; s1_valid = 1;
    cyc();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    rst = 0; s1_valid = 0; out_ready = 1;
    repeat (4) cyc();
    for (int i = 0; i < 3000; i++) begin
      s0_valid = $urandom_range(2) != 0; s0_data = $urandom;
      s1_valid = $urandom_range(2) != 0; s1_data = $urandom;
      out_ready = $urandom_range(3) != 0;
      rst = $urandom_range(499) == 0;
      cyc();
    end
    rst = 0; s0_valid = 0; s1_valid = 0; out_ready = 1;
    repeat (10) cyc();
    exp8[0] = 8'hAA; exp8[1] = 8'hBB; exp8[2] = 8'hCC; exp8[3] = 8'hDD;
    b_rst = 0; b_data = 32'hDDCCBBAA; b_valid = 1; b_ready = 1;
    #1;
    chk("w8_ready", b_s0r, 1);
    cyc();
    b_valid = 0;
    k = 0;
    for (int i = 0; i < 12 && k < 4; i++) begin
      if (b_ov) begin
        chk("w8_lane", b_out, exp8[k]);
        chk("w8_last", b_last, k == 3);
        k++;
      end
      cyc();
    end
    chk("w8_lane_count", k, 4);
    chk("w8_idle", b_ov, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
